// File: rtl/button_event_decoder.sv
// button_event_decoder (rev 1.0): press/release/short/long/auto-repeat event decoder for a debounced button.
// Define BUTTON_EVENT_REPEAT_EN to build the auto-repeat counter; otherwise repeatPulse is tied low.
`default_nettype none

module button_event_decoder #(
  parameter int TICK_DIV     = 50000,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        enable,
  input  logic        buttonIn,
  output logic        pressPulse,
  output logic        releasePulse,
  output logic        shortPress,
  output logic        longPress,
  output logic        repeatPulse,
  output logic        held,
  output logic [15:0] holdTicks
);

  localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [15:0]     LONG_VAL  = 16'(LONG_TICKS);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          prevBtn_q;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   holdTicks_q, holdTicks_d;
  logic          pressPulse_q, pressPulse_d;
  logic          releasePulse_q, releasePulse_d;
  logic          shortPress_q, shortPress_d;
  logic          longPress_q, longPress_d;
  logic          held_q, held_d;

  logic          rise, fall, tick;
  logic [15:0]   holdInc;

  assign rise    = buttonIn & ~prevBtn_q;
  assign fall    = ~buttonIn & prevBtn_q;
  assign tick    = (presc_q == PRESC_MAX);
  assign holdInc = (holdTicks_q == 16'hFFFF) ? holdTicks_q : holdTicks_q + 16'd1;

  always_comb begin
    state_d        = state_q;
    presc_d        = presc_q;
    holdTicks_d    = holdTicks_q;
    pressPulse_d   = 1'b0;
    releasePulse_d = 1'b0;
    shortPress_d   = 1'b0;
    longPress_d    = 1'b0;

    if (!enable) begin
      state_d = IDLE;
    end else begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (rise) begin
        presc_d = '0;
      end
      // A release always takes priority over a coincident tick.
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_d      = PRESSED;
            pressPulse_d = 1'b1;
            holdTicks_d  = 16'd0;
          end
        end
        PRESSED: begin
          if (fall) begin
            state_d        = IDLE;
            shortPress_d   = 1'b1;
            releasePulse_d = 1'b1;
          end else if (tick) begin
            holdTicks_d = holdInc;
            if (holdInc == LONG_VAL) begin
              state_d     = LONG_HELD;
              longPress_d = 1'b1;
            end
          end
        end
        LONG_HELD: begin
          if (fall) begin
            state_d        = IDLE;
            releasePulse_d = 1'b1;
          end else if (tick) begin
            holdTicks_d = holdInc;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    held_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q        <= IDLE;
      prevBtn_q      <= 1'b0;
      presc_q        <= '0;
      holdTicks_q    <= 16'd0;
      pressPulse_q   <= 1'b0;
      releasePulse_q <= 1'b0;
      shortPress_q   <= 1'b0;
      longPress_q    <= 1'b0;
      held_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      prevBtn_q      <= buttonIn;
      presc_q        <= presc_d;
      holdTicks_q    <= holdTicks_d;
      pressPulse_q   <= pressPulse_d;
      releasePulse_q <= releasePulse_d;
      shortPress_q   <= shortPress_d;
      longPress_q    <= longPress_d;
      held_q         <= held_d;
    end
  end

`ifdef BUTTON_EVENT_REPEAT_EN
  localparam int            RW      = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
  localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_TICKS - 1);

  logic [RW-1:0] rep_q, rep_d;
  logic          repeatPulse_q, repeatPulse_d;
  logic          enterLong, repTick;

  assign enterLong = (state_q == PRESSED) && (state_d == LONG_HELD);
  assign repTick   = (state_q == LONG_HELD) && (state_d == LONG_HELD) && tick;

  always_comb begin
    rep_d         = rep_q;
    repeatPulse_d = 1'b0;
    if (enterLong) begin
      rep_d = '0;
    end else if (repTick) begin
      if (rep_q == REP_MAX) begin
        rep_d         = '0;
        repeatPulse_d = 1'b1;
      end else begin
        rep_d = rep_q + RW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rep_q         <= '0;
      repeatPulse_q <= 1'b0;
    end else begin
      rep_q         <= rep_d;
      repeatPulse_q <= repeatPulse_d;
    end
  end

  assign repeatPulse = repeatPulse_q;
`else
  assign repeatPulse = 1'b0;
`endif

  assign pressPulse   = pressPulse_q;
  assign releasePulse = releasePulse_q;
  assign shortPress   = shortPress_q;
  assign longPress    = longPress_q;
  assign held         = held_q;
  assign holdTicks    = holdTicks_q;

endmodule

`default_nettype wire

// File: tb/tb_button_event_decoder.sv
// tb_button_event_decoder: event scoreboard bench for button_event_decoder (TICK_DIV=4, LONG_TICKS=5, REPEAT_TICKS=3).
`timescale 1ns/1ps
`default_nettype none

module tb_button_event_decoder;
  localparam int TD = 4;
  localparam int LT = 5;
  localparam int RT = 3;

  // kind: 0 press, 1 release, 2 short, 3 long, 4 repeat
  typedef struct packed {
    int cyc;
    int kind;
  } ev_t;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        enable = 1'b0;
  logic        buttonIn = 1'b0;
  logic        pressPulse, releasePulse, shortPress, longPress, repeatPulse, held;
  logic [15:0] holdTicks;

  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  ev_t  exp_q[$];
  ev_t  obs_q[$];

  button_event_decoder #(
    .TICK_DIV    (TD),
    .LONG_TICKS  (LT),
    .REPEAT_TICKS(RT)
  ) dut (
    .clk         (clk),
    .resetN      (resetN),
    .enable      (enable),
    .buttonIn    (buttonIn),
    .pressPulse  (pressPulse),
    .releasePulse(releasePulse),
    .shortPress  (shortPress),
    .longPress   (longPress),
    .repeatPulse (repeatPulse),
    .held        (held),
    .holdTicks   (holdTicks)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t mk(input int c, input int k);
    ev_t e;
    e.cyc  = c;
    e.kind = k;
    return e;
  endfunction

  // Advance n cycles, logging every observed pulse at the falling edge.
  task automatic run_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      if (pressPulse)   obs_q.push_back(mk(cyc, 0));
      if (releasePulse) obs_q.push_back(mk(cyc, 1));
      if (shortPress)   obs_q.push_back(mk(cyc, 2));
      if (longPress)    obs_q.push_back(mk(cyc, 3));
      if (repeatPulse)  obs_q.push_back(mk(cyc, 4));
    end
  endtask

  // Reference model: events for a press whose first high sample is at cycle c0, held for n cycles.
  task automatic expect_press(input int c0, input int n);
    int counted;
    counted = (n - 1) / TD;
    exp_q.push_back(mk(c0, 0));
    if (counted >= LT) begin
      exp_q.push_back(mk(c0 + LT * TD, 3));
`ifdef BUTTON_EVENT_REPEAT_EN
      for (int t = LT + RT; t * TD < n; t += RT) exp_q.push_back(mk(c0 + t * TD, 4));
`endif
      exp_q.push_back(mk(c0 + n, 1));
    end else begin
      exp_q.push_back(mk(c0 + n, 1));
      exp_q.push_back(mk(c0 + n, 2));
    end
  endtask

  task automatic do_press(input int n, output int c0);
    buttonIn = 1'b1;
    c0 = cyc + 1;
    run_cycles(n);
    buttonIn = 1'b0;
  endtask

  task automatic test_reset();
    int  c0;
    ev_t e, o;
    resetN = 1'b0; enable = 1'b1; buttonIn = 1'b1;
    run_cycles(3);
    n_total++;
    if ({pressPulse, releasePulse, shortPress, longPress, repeatPulse, held} !== 6'b0)
      $display("FAIL reset_outputs: got %b want 000000",
               {pressPulse, releasePulse, shortPress, longPress, repeatPulse, held});
    else n_pass++;
    n_total++;
    if (holdTicks !== 16'd0) $display("FAIL reset_holdTicks: got %0d want 0", holdTicks);
    else n_pass++;
    resetN = 1'b1;
    c0 = cyc + 1;
    run_cycles(6);
    buttonIn = 1'b0;
    expect_press(c0, 6);
    run_cycles(3);
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = mk(-1, -1); o = mk(-1, -1);
      if (exp_q.size() != 0) e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front();
      n_total++;
      if (o !== e) $display("FAIL reset_evt: got cyc=%0d kind=%0d want cyc=%0d kind=%0d", o.cyc, o.kind, e.cyc, e.kind);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_press();
    int  c0;
    ev_t e, o;
    buttonIn = 1'b1;
    c0 = cyc + 1;
    exp_q.push_back(mk(c0, 0));
    run_cycles(10);
    #2 resetN = 1'b0;
    #1;
    n_total++;
    if (held !== 1'b0) $display("FAIL async_reset_held: got %b want 0", held);
    else n_pass++;
    @(negedge clk);
    buttonIn = 1'b0;
    run_cycles(2);
    resetN = 1'b1;
    run_cycles(4);
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = mk(-1, -1); o = mk(-1, -1);
      if (exp_q.size() != 0) e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front();
      n_total++;
      if (o !== e) $display("FAIL midreset_evt: got cyc=%0d kind=%0d want cyc=%0d kind=%0d", o.cyc, o.kind, e.cyc, e.kind);
      else n_pass++;
    end
  endtask

  task automatic test_short_press();
    int  c0;
    ev_t e, o;
    do_press(13, c0);
    expect_press(c0, 13);
    n_total++;
    if (held !== 1'b1 || holdTicks !== 16'd3)
      $display("FAIL short_hold: got held=%b ticks=%0d want held=1 ticks=3", held, holdTicks);
    else n_pass++;
    run_cycles(3);
    n_total++;
    if (held !== 1'b0 || holdTicks !== 16'd3)
      $display("FAIL short_idle: got held=%b ticks=%0d want held=0 ticks=3", held, holdTicks);
    else n_pass++;
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = mk(-1, -1); o = mk(-1, -1);
      if (exp_q.size() != 0) e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front();
      n_total++;
      if (o !== e) $display("FAIL short_evt: got cyc=%0d kind=%0d want cyc=%0d kind=%0d", o.cyc, o.kind, e.cyc, e.kind);
      else n_pass++;
    end
  endtask

  task automatic test_long_press(input int n);
    int  c0;
    ev_t e, o;
    do_press(n, c0);
    expect_press(c0, n);
    n_total++;
    if (held !== 1'b1 || holdTicks !== 16'((n - 1) / TD))
      $display("FAIL long_hold: got held=%b ticks=%0d want held=1 ticks=%0d", held, holdTicks, (n - 1) / TD);
    else n_pass++;
    run_cycles(3);
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = mk(-1, -1); o = mk(-1, -1);
      if (exp_q.size() != 0) e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front();
      n_total++;
      if (o !== e) $display("FAIL long_evt: got cyc=%0d kind=%0d want cyc=%0d kind=%0d", o.cyc, o.kind, e.cyc, e.kind);
      else n_pass++;
    end
  endtask

  task automatic test_release_on_tick();
    int  c0;
    ev_t e, o;
    do_press(20, c0);
    expect_press(c0, 20);
    run_cycles(3);
    n_total++;
    if (holdTicks !== 16'd4) $display("FAIL tick_release_ticks: got %0d want 4", holdTicks);
    else n_pass++;
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = mk(-1, -1); o = mk(-1, -1);
      if (exp_q.size() != 0) e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front();
      n_total++;
      if (o !== e) $display("FAIL tick_release_evt: got cyc=%0d kind=%0d want cyc=%0d kind=%0d", o.cyc, o.kind, e.cyc, e.kind);
      else n_pass++;
    end
  endtask

  task automatic test_enable();
    int  c0;
    ev_t e, o;
    buttonIn = 1'b1;
    c0 = cyc + 1;
    exp_q.push_back(mk(c0, 0));
    run_cycles(10);
    enable = 1'b0;
    run_cycles(3);
    n_total++;
    if (held !== 1'b0 || holdTicks !== 16'd2)
      $display("FAIL disable_state: got held=%b ticks=%0d want held=0 ticks=2", held, holdTicks);
    else n_pass++;
    enable = 1'b1;
    run_cycles(6);
    n_total++;
    if (held !== 1'b0) $display("FAIL reenable_held: got %b want 0", held);
    else n_pass++;
    buttonIn = 1'b0;
    run_cycles(2);
    do_press(6, c0);
    expect_press(c0, 6);
    run_cycles(3);
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = mk(-1, -1); o = mk(-1, -1);
      if (exp_q.size() != 0) e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front();
      n_total++;
      if (o !== e) $display("FAIL enable_evt: got cyc=%0d kind=%0d want cyc=%0d kind=%0d", o.cyc, o.kind, e.cyc, e.kind);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int  c0;
    ev_t e, o;
    do_press(6, c0);
    expect_press(c0, 6);
    run_cycles(1);
    do_press(9, c0);
    expect_press(c0, 9);
    run_cycles(3);
    n_total++;
    if (holdTicks !== 16'd2) $display("FAIL b2b_ticks: got %0d want 2", holdTicks);
    else n_pass++;
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = mk(-1, -1); o = mk(-1, -1);
      if (exp_q.size() != 0) e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front();
      n_total++;
      if (o !== e) $display("FAIL b2b_evt: got cyc=%0d kind=%0d want cyc=%0d kind=%0d", o.cyc, o.kind, e.cyc, e.kind);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_short_press();
    test_long_press(45);
    test_release_on_tick();
    test_enable();
    test_back_to_back();
    test_long_press(100);
    test_reset_mid_press();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/button_event_decoder.md
BUTTON_EVENT_DECODER -- requirements
Module: button_event_decoder

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000, clk cycles per hold tick (≥2).
REQ-002 SHALL have parameter LONG_TICKS, default 1000, ticks held before a long press (1..65535).
REQ-003 SHALL have parameter REPEAT_TICKS, default 200, ticks between auto-repeat pulses (≥1).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port resetN, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port enable, input, 1, event decoding enable.
REQ-007 SHALL have port buttonIn, input, 1, debounced button level, synchronous to clk.
REQ-008 SHALL have port pressPulse, output, 1, one-cycle pulse on a press.
REQ-009 SHALL have port releasePulse, output, 1, one-cycle pulse on any release.
REQ-010 SHALL have port shortPress, output, 1, one-cycle pulse on a release before the long threshold.
REQ-011 SHALL have port longPress, output, 1, one-cycle pulse when the long threshold is reached.
REQ-012 SHALL have port repeatPulse, output, 1, one-cycle auto-repeat pulse while long-held.
REQ-013 SHALL have port held, output, 1, high while the state is PRESSED or LONG_HELD.
REQ-014 SHALL have port holdTicks, output, 16, ticks elapsed in the current or last press.

Function
REQ-015 SHALL register buttonIn into prevBtn every cycle, regardless of enable; rise = buttonIn & ~prevBtn; fall = ~buttonIn & prevBtn.
REQ-016 SHALL implement states IDLE, PRESSED, LONG_HELD; all outputs registered; every pulse exactly one cycle wide.
REQ-017 SHALL run a prescaler 0..TICK_DIV-1 with tick high on the count TICK_DIV-1, cleared to 0 on rise so tick 1 falls TICK_DIV cycles after the press.
REQ-018 IDLE, on rise: SHALL go to PRESSED, assert pressPulse on the next cycle, and clear holdTicks to 0.
REQ-019 PRESSED, on each tick: SHALL increment holdTicks; when the new value equals LONG_TICKS, SHALL go to LONG_HELD and pulse longPress.
REQ-020 PRESSED, on fall: SHALL go to IDLE and pulse shortPress and releasePulse in the same cycle.
REQ-021 LONG_HELD: SHALL pulse repeatPulse every REPEAT_TICKS ticks, the first at LONG_TICKS+REPEAT_TICKS ticks; on fall, SHALL go to IDLE and pulse releasePulse only.
REQ-022 holdTicks SHALL saturate at 16'hFFFF and hold its value in IDLE until the next press.
REQ-023 Release and tick in the same cycle: release SHALL win; in PRESSED this gives shortPress with no longPress, and the tick is not counted.
REQ-024 enable low: SHALL force IDLE, hold all pulses and held at 0, freeze holdTicks, and stop the prescaler; a fall in PRESSED or LONG_HELD while enable is low SHALL produce no pulse.
REQ-025 A press SHALL be recognised only on a rise seen with enable high; re-enabling with buttonIn high SHALL NOT produce pressPulse.

Reset
REQ-026 On resetN low: SHALL force state IDLE, prescaler 0, prevBtn 0, repeat counter 0, all pulses 0, held 0, holdTicks 0, asynchronously.
REQ-027 Reset asserted mid-press SHALL discard the press with no releasePulse; after reset release, a buttonIn already high counts as a rise.

Configuration
REQ-028 With macro BUTTON_EVENT_REPEAT_EN defined: SHALL build the repeat counter and drive repeatPulse per REQ-021.
REQ-029 Without BUTTON_EVENT_REPEAT_EN: SHALL omit the repeat counter and tie repeatPulse to 0; all other behaviour is unchanged.

Verification (TICK_DIV=4, LONG_TICKS=5, REPEAT_TICKS=3, macro defined unless stated)
REQ-030 Reset: resetN low with buttonIn=1 -> all outputs 0, holdTicks=0; release resetN -> pressPulse one cycle later.
REQ-031 Short press, buttonIn high 13 cycles -> one pressPulse; holdTicks=3; on release shortPress and releasePulse in the same cycle; longPress never asserted.
REQ-032 Long press, buttonIn high 45 cycles -> longPress 20 cycles after the press; repeatPulse at 32 and 44; on release releasePulse only, no shortPress.
REQ-033 Release coincident with the 5th tick -> shortPress and releasePulse; no longPress; holdTicks=4.
REQ-034 enable dropped at cycle 10 of a hold -> held=0 with no pulses; enable raised with buttonIn still high -> no pressPulse; next fresh press detected normally.
REQ-035 Macro undefined, buttonIn held 100 cycles -> longPress once; repeatPulse constant 0.
